// File: rtl/bsram_mem_be.sv
// Single-port byte-enable sync RAM, valid/ready req/rsp; optional MEM_PARITY_EN adds per-byte even parity.
// Latency: READ_LAT (1 or 2) edges from accept to rsp_valid; 1 request per cycle sustained.
// Backpressure: whole pipe and array output freeze while rsp_valid && !rsp_ready; req_ready drops then.
module bsram_mem_be #(
  parameter int    ADDR_W     = 11,
  parameter int    DATA_W     = 32,
  parameter int    READ_LAT   = 1,
  parameter int    WRITE_MODE = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                inj_perr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_perr
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("bsram_mem_be: READ_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("bsram_mem_be: DATA_W must be a multiple of 8");
  end

  logic adv, acc, wr;
  assign adv       = !rsp_valid || rsp_ready;
  assign req_ready = adv;
  assign acc       = req_valid && adv;
  assign wr        = acc && req_we;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] old_dat, mrg_dat, arr_dat_d;
  logic              arr_perr_d;

  always_comb begin
    old_dat = mem_q[req_addr];
    mrg_dat = old_dat;
    for (int i = 0; i < NB; i++) begin
      if (req_be[i]) mrg_dat[i*8 +: 8] = req_wdata[i*8 +: 8];
    end
    arr_dat_d = (req_we && WRITE_MODE == 1) ? mrg_dat : old_dat;
  end

  // Memory has no reset: contents survive reset_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr && req_be[i]) mem_q[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] old_par, mrg_par, sel_par;

  function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^w[i*8 +: 8];
    return p;
  endfunction

  always_comb begin
    old_par = par_q[req_addr];
    mrg_par = old_par;
    for (int i = 0; i < NB; i++) begin
      if (req_be[i]) mrg_par[i] = (^req_wdata[i*8 +: 8]) ^ inj_perr;
    end
    sel_par    = (req_we && WRITE_MODE == 1) ? mrg_par : old_par;
    arr_perr_d = |(sel_par ^ lane_par(arr_dat_d));
  end

  always_ff @(posedge clk) begin
    if (wr) par_q[req_addr] <= mrg_par;
  end
`else
  logic unused_inj;
  assign unused_inj = inj_perr;
  assign arr_perr_d = 1'b0;
`endif

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_perr_q, rsp_perr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  if (READ_LAT == 2) begin : g_lat2
    logic              v1_q, v1_d, p1_q, p1_d;
    logic [DATA_W-1:0] d1_q, d1_d;

    // A stage-2 bubble makes adv true, so stage 1 can move up even with rsp_ready low.
    always_comb begin
      v1_d        = v1_q;
      d1_d        = d1_q;
      p1_d        = p1_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_perr_d  = rsp_perr_q;
      if (adv) begin
        v1_d        = req_valid;
        rsp_valid_d = v1_q;
        if (acc) begin
          d1_d = arr_dat_d;
          p1_d = arr_perr_d;
        end
        if (v1_q) begin
          rsp_rdata_d = d1_q;
          rsp_perr_d  = p1_q;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v1_q <= 1'b0;
        d1_q <= '0;
        p1_q <= 1'b0;
      end else begin
        v1_q <= v1_d;
        d1_q <= d1_d;
        p1_q <= p1_d;
      end
    end
  end else begin : g_lat1
    always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_perr_d  = rsp_perr_q;
      if (adv) rsp_valid_d = req_valid;
      if (acc) begin
        rsp_rdata_d = arr_dat_d;
        rsp_perr_d  = arr_perr_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_perr_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_perr_q  <= rsp_perr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_perr  = rsp_perr_q;

endmodule

// File: tb/tb_bsram_mem_be.sv
// Randomized bench: a READ_LAT=1/read-first and a READ_LAT=2/write-through instance share one
// request stream; each is scored against a word-level memory model with per-lane error flags.
`timescale 1ns/1ps
module tb_bsram_mem_be;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic [31:0] dat;
    logic        perr;
    bit          chk;
    int          cyc;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, req_valid, req_we, inj_perr, rsp_ready;
  logic [3:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready_w [2];
  logic          rsp_valid_w [2];
  logic          rsp_perr_w  [2];
  logic [31:0]   rsp_rdata_w [2];

  bsram_mem_be #(.ADDR_W(AW), .DATA_W(32), .READ_LAT(1), .WRITE_MODE(0), .INIT_FILE("")) u_lat1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .inj_perr(inj_perr), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_w[0]), .rsp_perr(rsp_perr_w[0]));

  bsram_mem_be #(.ADDR_W(AW), .DATA_W(32), .READ_LAT(2), .WRITE_MODE(1), .INIT_FILE("")) u_lat2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .inj_perr(inj_perr), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_w[1]), .rsp_perr(rsp_perr_w[1]));

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          exact_mode = 1'b0;
  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [31:0] mem_m [2][DEPTH];
  logic [3:0]  err_m [2][DEPTH];
  logic [3:0]  def_m [2][DEPTH];
  bit          stall_prev [2];
  logic [31:0] dat_prev   [2];
  logic        perr_prev  [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Instance 0 returns the old word on writes, instance 1 the merged word.
  task automatic model_accept(input int d);
    logic [31:0] w;
    logic [3:0]  e, df;
    exp_t        x;
    w  = mem_m[d][req_addr];
    e  = err_m[d][req_addr];
    df = def_m[d][req_addr];
    x.dat  = w;
    x.perr = |e;
    x.chk  = (df == 4'hF);
    if (req_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) begin
          w[i*8 +: 8] = req_wdata[i*8 +: 8];
          e[i]        = PAR & inj_perr;
          df[i]       = 1'b1;
        end
      end
      mem_m[d][req_addr] = w;
      err_m[d][req_addr] = e;
      def_m[d][req_addr] = df;
      if (d == 1) begin
        x.dat  = w;
        x.perr = |e;
        x.chk  = (df == 4'hF);
      end
    end
    x.cyc   = cyc;
    x.exact = exact_mode;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic observe(input int d);
    exp_t x;
    int   qn;
    check_eq($sformatf("req_ready_L%0d", d + 1), 32'(req_ready_w[d]),
             32'(!rsp_valid_w[d] || rsp_ready));
    if (stall_prev[d]) begin
      check_eq($sformatf("hold_valid_L%0d", d + 1), 32'(rsp_valid_w[d]), 32'd1);
      check_eq($sformatf("hold_rdata_L%0d", d + 1), rsp_rdata_w[d], dat_prev[d]);
      check_eq($sformatf("hold_perr_L%0d", d + 1), 32'(rsp_perr_w[d]), 32'(perr_prev[d]));
    end
    stall_prev[d] = rsp_valid_w[d] && !rsp_ready;
    dat_prev[d]   = rsp_rdata_w[d];
    perr_prev[d]  = rsp_perr_w[d];
    if (rsp_valid_w[d] && rsp_ready) begin
      qn = (d == 0) ? q0.size() : q1.size();
      if (qn == 0) begin
        check_eq($sformatf("spurious_rsp_L%0d", d + 1), 32'(rsp_valid_w[d]), 32'd0);
      end else begin
        if (d == 0) x = q0.pop_front();
        else        x = q1.pop_front();
        if (x.chk) begin
          check_eq($sformatf("rdata_L%0d", d + 1), rsp_rdata_w[d], x.dat);
          check_eq($sformatf("perr_L%0d", d + 1), 32'(rsp_perr_w[d]), 32'(x.perr));
        end
        if (x.exact) check_eq($sformatf("latency_L%0d", d + 1), 32'(cyc - x.cyc), 32'(d + 1));
        else check_eq($sformatf("latency_min_L%0d", d + 1), 32'((cyc - x.cyc) >= d + 1), 32'd1);
      end
    end
    if (req_valid && req_ready_w[d]) model_accept(d);
  endtask

  task automatic step(input bit v, input bit we, input logic [3:0] be, input logic [AW-1:0] a,
                      input logic [31:0] wd, input bit inj, input bit rr);
    req_valid = v;  req_we = we;  req_be = be;  req_addr = a;
    req_wdata = wd; inj_perr = inj; rsp_ready = rr;
    #1;
    observe(0);
    observe(1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be, input bit inj);
    step(1'b1, 1'b1, be, a, wd, inj, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      stall_prev[d] = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        mem_m[d][a] = '0;
        err_m[d][a] = '0;
        def_m[d][a] = '0;
      end
    end
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
    req_addr = '0; req_wdata = '0; inj_perr = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_valid_L%0d", d + 1), 32'(rsp_valid_w[d]), 32'd0);
      check_eq($sformatf("rst_rdata_L%0d", d + 1), rsp_rdata_w[d], 32'd0);
      check_eq($sformatf("rst_perr_L%0d", d + 1), 32'(rsp_perr_w[d]), 32'd0);
    end
    reset_n = 1'b1;

    // Directed traffic with rsp_ready held high: latency must be exact.
    exact_mode = 1'b1;
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), $urandom, 4'hF, 1'b0);
    wr(4'd3, 32'h00B3_0513, 4'hF, 1'b0);
    rd(4'd3);
    wr(4'd5, 32'h1122_3344, 4'hF, 1'b0);
    wr(4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd(4'd5);
    wr(4'd6, $urandom, 4'b0000, 1'b0);
    rd(4'd6);
    for (int a = 0; a < 8; a++) rd(AW'(a));
    wr(4'd9, 32'h1234_5678, 4'hF, 1'b0);
    wr(4'd9, $urandom, 4'b0010, 1'b1);
    rd(4'd9);
    wr(4'd9, $urandom, 4'b0010, 1'b0);
    rd(4'd9);
    repeat (3) idle();
    exact_mode = 1'b0;

    // Stall mid-stream for four cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, AW'(i), 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, AW'(4 + i), 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, AW'(8 + i), 32'h0, 1'b0, 1'b1);
    repeat (3) idle();

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), AW'($urandom),
           $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    repeat (4) idle();

    // Reset with reads in flight and a stalled response.
    step(1'b1, 1'b0, 4'h0, 4'd1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'd2, 32'h0, 1'b0, 1'b0);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("midrst_valid_L%0d", d + 1), 32'(rsp_valid_w[d]), 32'd0);
      check_eq($sformatf("midrst_rdata_L%0d", d + 1), rsp_rdata_w[d], 32'd0);
      stall_prev[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) idle();
    exact_mode = 1'b1;
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    repeat (3) idle();

    check_eq("leftover_L1", 32'(q0.size()), 32'd0);
    check_eq("leftover_L2", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
